// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: owner tags, FSM states
// and the fixed fetch access size.
package mem_port_arbiter_pkg;

    typedef logic arb_owner_t;

    localparam arb_owner_t ARB_OWNER_INST = 1'b0;
    localparam arb_owner_t ARB_OWNER_DATA = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_HOLD_I = 2'd1,
        ARB_HOLD_D = 2'd2
    } arb_state_e;

    // Fetches are always full-word reads.
    localparam logic [1:0] INST_SIZE = 2'd2;

    // HOLD state that keeps the port locked to the given owner.
    function automatic arb_state_e hold_state(input arb_owner_t owner);
        return (owner == ARB_OWNER_DATA) ? ARB_HOLD_D : ARB_HOLD_I;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_owner_fifo.sv
// arb_owner_fifo: 1-bit-wide synchronous FIFO recording which requester owns
// each accepted-but-unanswered memory transaction, oldest at the head.
// A push is accepted while full provided a pop happens in the same cycle.
module arb_owner_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DEPTH-1:0] slots;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head    = slots[rd_ptr];
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Storage, wrapping pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            slots  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                slots[wr_ptr] <= din;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM-like memory port between the fetch (inst)
// and load/store (data) requesters. One grant at a time, held until
// mem_addr_ok; responses are routed back in issue order via an owner FIFO.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin when both requesters
// are pending in IDLE; default build uses fixed data-over-inst priority).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    arb_state_e state;
    logic       grant_valid;
    arb_owner_t grant_owner;
    logic       xfer;
    logic       resp;
    logic       fifo_full;
    logic       fifo_empty;
    logic       head_owner;
`ifdef ARB_ROUND_ROBIN_EN
    arb_owner_t rr_last;
`endif

    // Pick the owner of the port this cycle; HOLD states lock it.
    always_comb begin
        grant_valid = 1'b0;
        grant_owner = ARB_OWNER_DATA;
        unique case (state)
            ARB_IDLE: begin
                if (!fifo_full && (inst_req || data_req)) begin
                    grant_valid = 1'b1;
                    if (inst_req && data_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                        grant_owner = (rr_last == ARB_OWNER_DATA) ? ARB_OWNER_INST : ARB_OWNER_DATA;
`else
                        grant_owner = ARB_OWNER_DATA;
`endif
                    end else begin
                        grant_owner = data_req ? ARB_OWNER_DATA : ARB_OWNER_INST;
                    end
                end
            end
            ARB_HOLD_I: begin
                grant_valid = 1'b1;
                grant_owner = ARB_OWNER_INST;
            end
            ARB_HOLD_D: begin
                grant_valid = 1'b1;
                grant_owner = ARB_OWNER_DATA;
            end
            default: grant_valid = 1'b0;
        endcase
        if (!resetn) begin
            grant_valid = 1'b0;
        end
    end

    assign xfer = grant_valid && mem_addr_ok;
    assign resp = resetn && mem_data_ok && !fifo_empty;

    // Forward the granted requester's fields to the memory port; idle payload is zero.
    always_comb begin
        mem_req      = grant_valid;
        mem_wr       = 1'b0;
        mem_size     = '0;
        mem_wstrb    = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        if (grant_valid) begin
            if (grant_owner == ARB_OWNER_DATA) begin
                mem_wr       = data_wr;
                mem_size     = data_size;
                mem_wstrb    = data_wstrb;
                mem_addr     = data_addr;
                mem_wdata    = data_wdata;
                data_addr_ok = mem_addr_ok;
            end else begin
                mem_size     = INST_SIZE;
                mem_addr     = inst_addr;
                inst_addr_ok = mem_addr_ok;
            end
        end
    end

    // Route the in-order response to the owner at the FIFO head.
    always_comb begin
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        inst_rdata   = '0;
        data_rdata   = '0;
        if (resp) begin
            if (head_owner == ARB_OWNER_DATA) begin
                data_data_ok = 1'b1;
                data_rdata   = mem_rdata;
            end else begin
                inst_data_ok = 1'b1;
                inst_rdata   = mem_rdata;
            end
        end
    end

    // Grant FSM. The mem_* outputs must follow the grant in the same cycle,
    // so only the state (and rr_last) is registered; outputs are decoded above.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ARB_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
            rr_last <= ARB_OWNER_INST;
`endif
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (grant_valid && !mem_addr_ok) begin
                        state <= hold_state(grant_owner);
                    end
                end
                ARB_HOLD_I, ARB_HOLD_D: begin
                    if (mem_addr_ok) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
`ifdef ARB_ROUND_ROBIN_EN
            if (xfer) begin
                rr_last <= grant_owner;
            end
`endif
        end
    end

    arb_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (xfer),
        .din    (grant_owner),
        .pop    (resp),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .head   (head_owner)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by a
// randomized run against a transaction-level model (owner queue, pending grant).
module tb_mem_port_arbiter;

    localparam int DEPTH = 4;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_OUTSTANDING(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1;
        data_addr = 32'h1234_5678; data_wdata = 32'hdead_beef; data_wstrb = 4'hf;
        @(negedge clk);
        checks++;
        if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0)
            $display("FAIL reset_ctrl got %b want 00000",
                     {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
        else passed++;
        checks++;
        if ({mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} !== '0)
            $display("FAIL reset_payload addr=%h wdata=%h want 0", mem_addr, mem_wdata);
        else passed++;
        next_cycle();
        inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0;
        next_cycle();
        resetn = 1'b1;
        next_cycle();
    endtask

    task automatic test_single_fetch();
        inst_req = 1'b1; inst_addr = 32'h1c00_0000; mem_addr_ok = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_req, inst_addr_ok, data_addr_ok} !== 3'b110)
            $display("FAIL fetch_accept got %b want 110", {mem_req, inst_addr_ok, data_addr_ok});
        else passed++;
        checks++;
        if ({mem_wr, mem_size, mem_addr} !== {1'b0, 2'd2, 32'h1c00_0000})
            $display("FAIL fetch_payload wr=%b size=%0d addr=%h", mem_wr, mem_size, mem_addr);
        else passed++;
        next_cycle();
        inst_req = 1'b0; mem_addr_ok = 1'b0;
        @(negedge clk);
        checks++;
        if (inst_data_ok !== 1'b0) $display("FAIL fetch_early got %b want 0", inst_data_ok);
        else passed++;
        next_cycle();
        mem_data_ok = 1'b1; mem_rdata = 32'h0280_0000;
        @(negedge clk);
        checks++;
        if ({inst_data_ok, data_data_ok, inst_rdata} !== {2'b10, 32'h0280_0000})
            $display("FAIL fetch_resp ok=%b%b rdata=%h want 10 02800000",
                     inst_data_ok, data_data_ok, inst_rdata);
        else passed++;
        next_cycle();
        mem_data_ok = 1'b0;
    endtask

    task automatic test_priority();
        inst_req = 1'b1; inst_addr = 32'h1c00_0040;
        data_req = 1'b1; data_addr = 32'h0000_8000; data_wr = 1'b1;
        data_size = 2'd2; data_wstrb = 4'b1010; data_wdata = 32'haabb_ccdd;
        mem_addr_ok = 1'b1;
        @(negedge clk);
        checks++;
        if ({data_addr_ok, inst_addr_ok, mem_addr, mem_wr, mem_wstrb, mem_wdata} !==
            {2'b10, 32'h0000_8000, 1'b1, 4'b1010, 32'haabb_ccdd})
            $display("FAIL prio_first dok=%b iok=%b addr=%h wr=%b", data_addr_ok,
                     inst_addr_ok, mem_addr, mem_wr);
        else passed++;
        next_cycle();
        data_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({data_addr_ok, inst_addr_ok, mem_addr} !== {2'b01, 32'h1c00_0040})
            $display("FAIL prio_second dok=%b iok=%b addr=%h", data_addr_ok, inst_addr_ok, mem_addr);
        else passed++;
        next_cycle();
        inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0000_00a0;
        @(negedge clk);
        checks++;
        if ({data_data_ok, inst_data_ok, data_rdata} !== {2'b10, 32'h0000_00a0})
            $display("FAIL prio_resp_a dok=%b iok=%b rdata=%h", data_data_ok, inst_data_ok, data_rdata);
        else passed++;
        next_cycle();
        mem_rdata = 32'h0000_00b0;
        @(negedge clk);
        checks++;
        if ({data_data_ok, inst_data_ok, inst_rdata} !== {2'b01, 32'h0000_00b0})
            $display("FAIL prio_resp_b dok=%b iok=%b rdata=%h", data_data_ok, inst_data_ok, inst_rdata);
        else passed++;
        next_cycle();
        mem_data_ok = 1'b0;
    endtask

    task automatic test_hold();
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_4444; mem_addr_ok = 1'b0;
        inst_addr = 32'h1c00_0100;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) inst_req = 1'b1;
            mem_addr_ok = (i == 3);
            @(negedge clk);
            checks++;
            if ({mem_req, mem_addr, inst_addr_ok, data_addr_ok} !== {1'b1, 32'h0000_4444, 1'b0, i == 3})
                $display("FAIL hold_%0d addr=%h iok=%b dok=%b", i, mem_addr, inst_addr_ok, data_addr_ok);
            else passed++;
            next_cycle();
        end
        data_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_addr, inst_addr_ok} !== {32'h1c00_0100, 1'b1})
            $display("FAIL hold_after addr=%h iok=%b want 1c000100 1", mem_addr, inst_addr_ok);
        else passed++;
        next_cycle();
        inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mem_rdata = 32'h100 + 32'(i);
            @(negedge clk);
            checks++;
            if ({data_data_ok, inst_data_ok} !== {i == 0, i == 1})
                $display("FAIL hold_resp_%0d dok=%b iok=%b", i, data_data_ok, inst_data_ok);
            else passed++;
            next_cycle();
        end
        mem_data_ok = 1'b0;
    endtask

    task automatic test_full();
        inst_req = 1'b1; mem_addr_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            inst_addr = 32'h1c00_0200 + 32'(4 * k);
            @(negedge clk);
            checks++;
            if (inst_addr_ok !== 1'b1) $display("FAIL full_fill_%0d got %b want 1", k, inst_addr_ok);
            else passed++;
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if ({mem_req, inst_addr_ok} !== 2'b00)
            $display("FAIL full_block req=%b iok=%b want 00", mem_req, inst_addr_ok);
        else passed++;
        next_cycle();
        mem_data_ok = 1'b1; mem_rdata = 32'h0000_0f00;
        @(negedge clk);
        checks++;
        if ({mem_req, inst_data_ok, inst_rdata} !== {2'b01, 32'h0000_0f00})
            $display("FAIL full_pop req=%b iok=%b rdata=%h", mem_req, inst_data_ok, inst_rdata);
        else passed++;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({mem_req, inst_addr_ok, inst_data_ok} !== 3'b111)
            $display("FAIL full_pushpop got %b want 111", {mem_req, inst_addr_ok, inst_data_ok});
        else passed++;
        next_cycle();
        mem_data_ok = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_req, inst_addr_ok} !== 2'b11)
            $display("FAIL full_refill got %b want 11", {mem_req, inst_addr_ok});
        else passed++;
        next_cycle();
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) $display("FAIL full_again req=%b want 0", mem_req);
        else passed++;
        next_cycle();
        inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({inst_data_ok, data_data_ok} !== {k < 4, 1'b0})
                $display("FAIL full_drain_%0d iok=%b dok=%b", k, inst_data_ok, data_data_ok);
            else passed++;
            next_cycle();
        end
        mem_data_ok = 1'b0;
    endtask

    task automatic test_reset_mid();
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0010; mem_addr_ok = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (data_addr_ok !== 1'b1) $display("FAIL rstmid_issue_%0d got %b want 1", k, data_addr_ok);
            else passed++;
            next_cycle();
        end
        data_req = 1'b0; inst_req = 1'b1; resetn = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_req, inst_addr_ok, data_addr_ok, mem_addr} !== '0)
            $display("FAIL rstmid_out req=%b iok=%b addr=%h want 0", mem_req, inst_addr_ok, mem_addr);
        else passed++;
        next_cycle();
        resetn = 1'b1; inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
        @(negedge clk);
        checks++;
        if ({inst_data_ok, data_data_ok, mem_req} !== 3'b000)
            $display("FAIL rstmid_stray got %b want 000", {inst_data_ok, data_data_ok, mem_req});
        else passed++;
        next_cycle();
        mem_data_ok = 1'b0;
    endtask

    task automatic test_round_robin();
        bit want_data [4];
        inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b0; mem_addr_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            want_data[i] = RR ? (i % 2 == 0) : 1'b1;
            @(negedge clk);
            checks++;
            if ({data_addr_ok, inst_addr_ok} !== {want_data[i], !want_data[i]})
                $display("FAIL rr_grant_%0d dok=%b iok=%b", i, data_addr_ok, inst_addr_ok);
            else passed++;
            next_cycle();
        end
        inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({data_data_ok, inst_data_ok} !== {want_data[i], !want_data[i]})
                $display("FAIL rr_resp_%0d dok=%b iok=%b", i, data_data_ok, inst_data_ok);
            else passed++;
            next_cycle();
        end
        mem_data_ok = 1'b0;
    endtask

    // Reference: owner queue in issue order, a pending grant that survives until accepted,
    // and the last granted owner for round-robin tie breaks.
    task automatic test_random();
        bit q[$];
        int held = -1;
        bit last_owner = 1'b0;
        bit i_busy = 1'b0, d_busy = 1'b0;
        bit quiesce, ev, es, pop_e, own;
        for (int n = 0; n < 1520; n++) begin
            quiesce = (n >= 1500);
            if (!i_busy) begin
                inst_req = quiesce ? 1'b0 : 1'($urandom_range(0, 1));
                inst_addr = $urandom;
                i_busy = inst_req;
            end
            if (!d_busy) begin
                data_req = quiesce ? 1'b0 : 1'($urandom_range(0, 1));
                data_wr = 1'($urandom_range(0, 1));
                data_size = 2'($urandom_range(0, 2));
                data_wstrb = 4'($urandom);
                data_addr = $urandom;
                data_wdata = $urandom;
                d_busy = data_req;
            end
            mem_addr_ok = quiesce ? 1'b1 : ($urandom_range(0, 3) != 0);
            mem_data_ok = (q.size() > 0) && (quiesce || $urandom_range(0, 2) == 0);
            mem_rdata = $urandom;

            ev = 1'b0; es = 1'b1;
            if (held >= 0) begin
                ev = 1'b1; es = held[0];
            end else if (q.size() < DEPTH && (inst_req || data_req)) begin
                ev = 1'b1;
                es = (inst_req && data_req) ? (RR ? !last_owner : 1'b1) : data_req;
            end
            pop_e = mem_data_ok && (q.size() > 0);
            own = pop_e ? q[0] : 1'b0;

            @(negedge clk);
            checks++;
            if ({mem_req, inst_addr_ok, data_addr_ok} !==
                {ev, ev && !es && mem_addr_ok, ev && es && mem_addr_ok})
                $display("FAIL rnd_grant cyc%0d got %b want %b", n,
                         {mem_req, inst_addr_ok, data_addr_ok},
                         {ev, ev && !es && mem_addr_ok, ev && es && mem_addr_ok});
            else passed++;
            if (ev) begin
                checks++;
                if ({mem_wr, mem_size, mem_addr} !==
                    (es ? {data_wr, data_size, data_addr} : {1'b0, 2'd2, inst_addr}))
                    $display("FAIL rnd_payload cyc%0d wr=%b size=%0d addr=%h", n,
                             mem_wr, mem_size, mem_addr);
                else passed++;
            end
            checks++;
            if ({inst_data_ok, data_data_ok} !== {pop_e && !own, pop_e && own})
                $display("FAIL rnd_route cyc%0d got %b want %b", n,
                         {inst_data_ok, data_data_ok}, {pop_e && !own, pop_e && own});
            else passed++;
            if (pop_e) begin
                checks++;
                if ((own ? data_rdata : inst_rdata) !== mem_rdata)
                    $display("FAIL rnd_rdata cyc%0d got %h want %h", n,
                             own ? data_rdata : inst_rdata, mem_rdata);
                else passed++;
                void'(q.pop_front());
            end
            if (ev && mem_addr_ok) begin
                q.push_back(es);
                last_owner = es;
                if (es) d_busy = 1'b0;
                else i_busy = 1'b0;
            end
            held = (ev && !mem_addr_ok) ? int'(es) : -1;
            next_cycle();
        end
        inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        resetn = 1'b0; inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_wstrb = '0;
        data_addr = '0; data_wdata = '0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
        next_cycle();
        test_reset();
        test_single_fetch();
        test_priority();
        test_hold();
        test_full();
        test_reset_mid();
        test_round_robin();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
